// File: rtl/ifu_bht_pre_array_ctrl.sv
// Control stage in front of the BHT prediction array: init sweep, lookup vs. update
// arbitration, masked 2-bit counter writes and fixed-latency lookup return.
//
// state | meaning
// INIT  | sweeping INIT_DATA into every entry, one write per cycle
// RUN   | serving lookups, draining buffered counter updates when no lookup
module ifu_bht_pre_array_ctrl #(
  parameter int IDX_W      = 10,
  parameter int DATA_W     = 64,
  parameter int POS_W      = 5,
  parameter int WBUF_DEPTH = 2,
  parameter logic [DATA_W-1:0] INIT_DATA = 64'h3333_3333_3333_3333
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              cp0_bht_inv,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  input  logic              upd_req,
  output logic              upd_rdy,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic [POS_W-1:0]  upd_pos,
  input  logic [1:0]        upd_val,
  output logic              init_busy,
  output logic [IDX_W-1:0]  bht_pred_array_index,
  output logic              bht_pred_array_cen_b,
  output logic              bht_pred_array_gwen,
  output logic [DATA_W-1:0] bht_pred_bwen,
  output logic [DATA_W-1:0] bht_pred_array_din,
  output logic              bht_pre_array_clk_en,
  input  logic [DATA_W-1:0] bht_pre_data_out
);

  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic               acc_init, acc_rd, acc_wr;
  logic               rd_pend;

  logic [IDX_W-1:0]   wb_idx [WBUF_DEPTH];
  logic [POS_W-1:0]   wb_pos [WBUF_DEPTH];
  logic [1:0]         wb_val [WBUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   wb_cnt;
  logic               wb_empty, wb_full, push, pop, flush;

  logic [IDX_W-1:0]   head_idx;
  logic [POS_W-1:0]   head_pos;
  logic [1:0]         head_val;
  logic [DATA_W-1:0]  head_mask, head_din;

  assign wb_empty = (wb_cnt == '0);
  assign wb_full  = (wb_cnt == CNT_W'(WBUF_DEPTH));
  assign upd_rdy  = (state_q == ST_RUN) && !wb_full;
  assign flush    = (state_q == ST_RUN) && cp0_bht_inv;
  assign push     = upd_req && upd_rdy && !flush;
  assign pop      = acc_wr;
  assign rd_data  = bht_pre_data_out;

  assign head_idx  = wb_idx[rd_ptr];
  assign head_pos  = wb_pos[rd_ptr];
  assign head_val  = wb_val[rd_ptr];
  assign head_mask = {{(DATA_W-2){1'b0}}, 2'b11} << {head_pos, 1'b0};
  assign head_din  = {{(DATA_W-2){1'b0}}, head_val} << {head_pos, 1'b0};

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    acc_init = 1'b0;
    acc_rd   = 1'b0;
    acc_wr   = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (cp0_bht_inv) begin
          sweep_d = '0;
        end else begin
          acc_init = 1'b1;
          sweep_d  = sweep_q + 1'b1;
          if (sweep_q == '1) state_d = ST_RUN;
        end
      end
      default: begin
        if (cp0_bht_inv) begin
          state_d = ST_INIT;
          sweep_d = '0;
        end else if (rd_req) begin
          acc_rd = 1'b1;
        end else if (!wb_empty) begin
          acc_wr = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q   <= ST_INIT;
      sweep_q   <= '0;
      init_busy <= 1'b1;
      rd_pend   <= 1'b0;
      rd_vld    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      // lags the state by one cycle so it covers the last sweep write on the pins
      init_busy <= (state_q == ST_INIT);
      rd_pend   <= acc_rd;
      rd_vld    <= rd_pend && !cp0_bht_inv;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      bht_pred_array_index <= '0;
      bht_pred_array_cen_b <= 1'b1;
      bht_pred_array_gwen  <= 1'b1;
      bht_pred_bwen        <= '1;
      bht_pred_array_din   <= '0;
      bht_pre_array_clk_en <= 1'b0;
    end else if (acc_init) begin
      bht_pred_array_index <= sweep_q;
      bht_pred_array_cen_b <= 1'b0;
      bht_pred_array_gwen  <= 1'b0;
      bht_pred_bwen        <= '0;
      bht_pred_array_din   <= INIT_DATA;
      bht_pre_array_clk_en <= 1'b1;
    end else if (acc_rd) begin
      bht_pred_array_index <= rd_idx;
      bht_pred_array_cen_b <= 1'b0;
      bht_pred_array_gwen  <= 1'b1;
      bht_pred_bwen        <= '1;
      bht_pre_array_clk_en <= 1'b1;
    end else if (acc_wr) begin
      bht_pred_array_index <= head_idx;
      bht_pred_array_cen_b <= 1'b0;
      bht_pred_array_gwen  <= 1'b0;
      bht_pred_bwen        <= ~head_mask;
      bht_pred_array_din   <= head_din;
      bht_pre_array_clk_en <= 1'b1;
    end else begin
      bht_pred_array_cen_b <= 1'b0 | 1'b1;
      bht_pred_array_gwen  <= 1'b1;
      bht_pred_bwen        <= '1;
      bht_pre_array_clk_en <= 1'b0;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wb_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(WBUF_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(WBUF_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   wb_cnt <= wb_cnt + 1'b1;
        2'b01:   wb_cnt <= wb_cnt - 1'b1;
        default: wb_cnt <= wb_cnt;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (push) begin
      wb_idx[wr_ptr] <= upd_idx;
      wb_pos[wr_ptr] <= upd_pos;
      wb_val[wr_ptr] <= upd_val;
    end
  end

endmodule
